// File: rtl/amux_bus_arbiter.sv
// ============================================================================
// amux_bus_arbiter : two-channel round-robin arbiter for the chip analog mux
//                    buses, with break-before-make and settle sequencing.
// Revision 1.0
// ============================================================================
`default_nettype none

module amux_bus_arbiter #(
   parameter int N_REQ         = 4,
   parameter int BBM_CYCLES    = 2,
   parameter int SETTLE_CYCLES = 3,
   parameter int CW            = 4
) (
   input  logic             clk_i,
   input  logic             resetn_i,
   input  logic             amux_en_i,
   input  logic [N_REQ-1:0] req_i,
   input  logic [N_REQ-1:0] bus_sel_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [N_REQ-1:0] sw_a_en_o,
   output logic [N_REQ-1:0] sw_b_en_o,
   output logic [1:0]       busy_o
);

   localparam int IW = $clog2(N_REQ);
   localparam logic [CW-1:0] C_BBM_LOAD    = CW'(BBM_CYCLES - 1);
   localparam logic [CW-1:0] C_SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_BREAK   = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_GRANT   = 3'd3,
      ST_RELEASE = 3'd4
   } state_t;

   logic [N_REQ-1:0] gnt_ch_d [2];
   logic [N_REQ-1:0] sw_ch_q  [2];
   logic [1:0]       busy_ch_q;
   logic [N_REQ-1:0] gnt_q;

   for (genvar c = 0; c < 2; c++) begin : g_ch
      state_t           state_q, state_d;
      logic [CW-1:0]    cnt_q, cnt_d;
      logic [IW-1:0]    owner_q, owner_d;
      logic [IW-1:0]    ptr_q, ptr_d;
      logic [IW-1:0]    pick;
      logic [IW-1:0]    owner_nxt;
      logic             found;
      logic             owner_elig;
      logic [N_REQ-1:0] elig;
      logic [N_REQ-1:0] own_oh;
      logic [N_REQ-1:0] sw_q, sw_d;
      logic             busy_q;

      assign elig       = req_i & ((c == 1) ? bus_sel_i : ~bus_sel_i);
      assign owner_elig = elig[owner_q];
      assign owner_nxt  = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

      // First eligible requester at or after the round-robin pointer.
      always_comb begin
         int idx;
         idx   = 0;
         found = 1'b0;
         pick  = ptr_q;
         for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && elig[IW'(idx)]) begin
               found = 1'b1;
               pick  = IW'(idx);
            end
         end
      end

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         owner_d = owner_q;
         ptr_d   = ptr_q;
         if (!amux_en_i) begin
            state_d = ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (found) begin
                     owner_d = pick;
                     state_d = ST_BREAK;
                     cnt_d   = C_BBM_LOAD;
                  end
               end
               ST_BREAK, ST_SETTLE: begin
                  if (!owner_elig) begin
                     ptr_d   = owner_nxt;
                     state_d = ST_RELEASE;
                     cnt_d   = C_BBM_LOAD;
                  end else if (cnt_q == '0) begin
                     state_d = (state_q == ST_BREAK) ? ST_SETTLE : ST_GRANT;
                     cnt_d   = C_SETTLE_LOAD;
                  end else begin
                     cnt_d = cnt_q - 1'b1;
                  end
               end
               ST_GRANT: begin
                  if (!owner_elig) begin
                     ptr_d   = owner_nxt;
                     state_d = ST_RELEASE;
                     cnt_d   = C_BBM_LOAD;
                  end
               end
               ST_RELEASE: begin
                  if (cnt_q == '0) state_d = ST_IDLE;
                  else             cnt_d   = cnt_q - 1'b1;
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end

      // Switch and grant are pure decodes of the next state, so opening
      // always coincides with leaving SETTLE/GRANT.
      always_comb begin
         own_oh = N_REQ'(1) << owner_d;
         sw_d   = '0;
         if (state_d == ST_SETTLE || state_d == ST_GRANT) sw_d = own_oh;
      end

      assign gnt_ch_d[c] = (state_d == ST_GRANT) ? own_oh : '0;

      always_ff @(posedge clk_i) begin
         if (!resetn_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            sw_q    <= '0;
            busy_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            sw_q    <= sw_d;
            busy_q  <= (state_d != ST_IDLE);
         end
      end

      assign sw_ch_q[c]   = sw_q;
      assign busy_ch_q[c] = busy_q;
   end

   always_ff @(posedge clk_i) begin
      if (!resetn_i) gnt_q <= '0;
      else           gnt_q <= gnt_ch_d[0] | gnt_ch_d[1];
   end

   assign gnt_o     = gnt_q;
   assign sw_a_en_o = sw_ch_q[0];
   assign sw_b_en_o = sw_ch_q[1];
   assign busy_o    = busy_ch_q;

endmodule

`default_nettype wire
